imm_gen_pipe: RTL

- Pipelined, parametrised immediate generator for the upcoming multi-cycle/pipelined core.
- Takes a 32-bit instruction word plus a 3-bit format select. Produces an XLEN-wide extended immediate and an optional side tag (e.g. PC or rd).
- Registered valid/ready interface on both sides, with a 2-entry skid buffer.
- Adds U, shift-amount and CSR-zimm formats, an illegal-format flag, and a flush.

---
 rtl/imm_gen_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: combinational format decode feeding a
// 2-entry FIFO skid buffer with valid/ready handshakes on both sides.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state;
  logic [XLEN-1:0]  imm0, imm1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             err0, err1;

  logic [63:0]      imm_full;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             accept;
  logic             drain;
  logic             unused_bits;

  // Decode at 64 bits and truncate, so one table serves both XLEN values.
  always_comb begin
    imm_full = '0;
    dec_err  = 1'b0;
    case (in_src)
      3'b000: imm_full = {{52{in_instr[31]}}, in_instr[31:20]};
      3'b001: imm_full = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010: imm_full = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
      3'b011: imm_full = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
      3'b100: imm_full = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
      3'b101: begin
        if (XLEN == 64) imm_full = {58'b0, in_instr[25:20]};
        else            imm_full = {59'b0, in_instr[24:20]};
      end
      3'b110: imm_full = {59'b0, in_instr[19:15]};
      default: dec_err = 1'b1;
    endcase
  end

  assign dec_imm     = imm_full[XLEN-1:0];
  assign unused_bits = ^{in_instr[6:0], imm_full};

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_imm = imm0;
  assign out_tag = tag0;
  assign out_err = err0;

  // Slot 0 is always the head; slot 1 holds the second entry in TWO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      imm0  <= '0;
      imm1  <= '0;
      tag0  <= '0;
      tag1  <= '0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
      imm0  <= '0;
      imm1  <= '0;
      tag0  <= '0;
      tag1  <= '0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            imm0  <= dec_imm;
            tag0  <= in_tag;
            err0  <= dec_err;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            imm0 <= dec_imm;
            tag0 <= in_tag;
            err0 <= dec_err;
          end else if (accept) begin
            imm1  <= dec_imm;
            tag1  <= in_tag;
            err1  <= dec_err;
            state <= TWO;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            imm0  <= imm1;
            tag0  <= tag1;
            err0  <= err1;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
